fade_apply: RTL and testbench
=============================

Name: fade_apply

Overview:
- Downstream consumer of the multi-channel fader output stream (dv/chan/imag/real, 32 channels emitted chan 31 down to 0 once per fade update).
- Collects one complete set of per-channel complex fade coefficients into a ping-pong coefficient store and swaps banks atomically when the set is complete.
- Applies the active coefficient to a tagged complex sample stream by pipelined complex multiply, rounding and saturation.
- Output is the faded per-channel baseband sent to the channel-combining stage.

Parameters:
N, 32, number of fader channels
Wchan, 5, channel index width, equal to $clog2(N)
FRAC, 13, fraction bits of the fade coefficient; unity gain = 2^FRAC = 8192

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
fade_dv  in  1  fade coefficient valid strobe from the fader
fade_chan  in  Wchan  channel of the coefficient
fade_real  in  16  signed coefficient, real part
fade_imag  in  16  signed coefficient, imaginary part
s_valid  in  1  input sample valid
s_chan  in  Wchan  channel tag of the input sample
s_real  in  16  signed sample, real part
s_imag  in  16  signed sample, imaginary part
m_valid  out  1  output sample valid
m_chan  out  Wchan  channel tag, passed through
m_real  out  16  signed faded sample, real part
m_imag  out  16  signed faded sample, imaginary part
fade_ready  out  1  sticky; high after the first bank swap
bank_swap  out  1  one-cycle pulse on each bank swap
frame_err  out  1  one-cycle pulse when an incomplete set is terminated

Behaviour:
- Reset (async assert, sync release): rd_bank=0, written mask=0, fade_ready=0, m_valid=0, bank_swap=0, frame_err=0, m_chan/m_real/m_imag=0, all pipeline valids=0. Coefficient RAM contents are not reset.
- Store: 2 banks x N entries x 32 bits. Writes go to bank ~rd_bank; reads come from rd_bank. A read and a write in the same cycle never address the same bank, so there is no collision.
- Write path: when fade_dv=1, write {real,imag} at [~rd_bank][fade_chan] and set mask[fade_chan]. Arrival order is free and duplicate writes overwrite.
- Termination: the write with fade_chan==0 ends the set.
  - If the mask including this write is all ones: on the next edge rd_bank toggles, mask clears, bank_swap pulses, and fade_ready sets.
  - Otherwise: the mask clears, frame_err pulses, and there is no swap. The old bank stays active.
- Read pipeline, fixed latency 4 with no backpressure. Every s_valid produces exactly one m_valid 4 cycles later.
  - C1: register the sample and channel. Address the RAM with {rd_bank, s_chan}; the bank is sampled at this edge. A swap on the same edge affects only later samples.
  - C2: register the four 32-bit products sr*fr, si*fi, sr*fi, si*fr.
  - C3: re = sr*fr - si*fi and im = sr*fi + si*fr, both 33-bit signed.
  - C4: add 2^(FRAC-1), arithmetic shift right by FRAC, saturate to [-32768, 32767], then register the outputs.
- While fade_ready=0, samples still flow through the pipeline with m_valid asserted, but m_real and m_imag are forced to 0.
- m_chan is s_chan delayed by 4 cycles. When m_valid=0, the data outputs hold their last values.
- Reset asserted mid-set discards the partial mask. Reset mid-pipeline drops samples in flight.

Decomposition:
- Package fader_pkg holds:
  - N_CHAN=32, W_CHAN=5, FADE_FRAC=13, FADE_APPLY_LAT=4
  - typedef cplx16_t (packed struct with signed [15:0] re, im)
- One sub-module, cmult_q13: a 3-stage complex multiply with round and saturate, parameterised by FRAC.
- The RAM is inferred inside fade_apply.

Test Plan:
1. Unity: load all 32 channels with (8192, 0), chan 31 down to 0.
   - Required: bank_swap pulses once and fade_ready=1.
   - Input ch5 (1000, -200) -> m_valid 4 cycles later with ch5 (1000, -200).
2. Rotation: load ch7 = (0, 8192), other channels unity.
   - Input ch7 (1000, 200) -> (-200, 1000).
   - Input ch6 (1000, 200) -> (1000, 200).
3. Saturation and rounding:
   - ch0 = (16376, 16376), input (32767, 0) -> (32767, 32767).
   - ch1 = (-16376, 0), input (32767, 0) -> (-32768, 0).
   - ch2 = (4096, 0), input (3, 0) -> (2, 0), since 1.5 rounds up.
4. Incomplete set: after a valid load, send chans 31..5 then 0.
   - Required: frame_err pulses, no bank_swap, outputs still use the previous coefficients.
   - Then send a full 31..0 set -> bank_swap.
5. Swap boundary: stream samples on ch3 every cycle while a new set (ch3 = (0, 8192)) completes.
   - Required: samples entering C1 at or before the swap edge use the old coefficient; later samples use the new one. No gaps and no duplicates.
6. Reset and not-ready behaviour:
   - Pulse reset mid-load -> fade_ready=0 and m_valid=0 immediately.
   - Samples then give m_valid with (0, 0) until a full set is loaded.

Source files
------------

// File: rtl/fader_pkg.sv
// Shared types and constants for the fader datapath.
// Coefficients are Q2.13 complex values; samples are 16-bit signed complex.
package fader_pkg;

    localparam int unsigned N_CHAN         = 32;
    localparam int unsigned W_CHAN         = 5;
    localparam int unsigned FADE_FRAC      = 13;
    localparam int unsigned FADE_APPLY_LAT = 4;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx16_t;

    function automatic logic signed [15:0] sat16(input logic signed [33:0] x);
        if (x > 34'sd32767) begin
            return 16'sh7fff;
        end else if (x < -34'sd32768) begin
            return 16'sh8000;
        end
        return x[15:0];
    endfunction

endpackage

// File: rtl/cmult_q13.sv
// Three-stage complex multiply: products, sum/difference, then round-half-up,
// arithmetic shift by FRAC and saturation to 16 bits. A tag rides alongside.
module cmult_q13
    import fader_pkg::*;
#(
    parameter int unsigned FRAC = 13,
    parameter int unsigned TagW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [TagW-1:0] tag_i,
    input  cplx16_t         a_i,
    input  cplx16_t         b_i,
    output logic            valid_o,
    output logic [TagW-1:0] tag_o,
    output cplx16_t         y_o
);

    localparam logic signed [33:0] RndHalf = 34'sd1 <<< (FRAC - 1);

    logic signed [31:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [32:0] re_q, im_q;
    logic               v2_q, v3_q, v4_q;
    logic [TagW-1:0]    tag2_q, tag3_q, tag4_q;
    cplx16_t            y_q, y_d;
    logic signed [33:0] re_rnd, im_rnd, re_sh, im_sh;

    always_comb begin
        re_rnd  = 34'(re_q) + RndHalf;
        im_rnd  = 34'(im_q) + RndHalf;
        re_sh   = re_rnd >>> FRAC;
        im_sh   = im_rnd >>> FRAC;
        y_d.re  = sat16(re_sh);
        y_d.im  = sat16(im_sh);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            v4_q   <= 1'b0;
            tag2_q <= '0;
            tag3_q <= '0;
            tag4_q <= '0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            re_q   <= '0;
            im_q   <= '0;
            y_q    <= '0;
        end else begin
            v2_q <= valid_i;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (valid_i) begin
                tag2_q <= tag_i;
                p_rr_q <= $signed(a_i.re) * $signed(b_i.re);
                p_ii_q <= $signed(a_i.im) * $signed(b_i.im);
                p_ri_q <= $signed(a_i.re) * $signed(b_i.im);
                p_ir_q <= $signed(a_i.im) * $signed(b_i.re);
            end
            if (v2_q) begin
                tag3_q <= tag2_q;
                re_q   <= 33'(p_rr_q) - 33'(p_ii_q);
                im_q   <= 33'(p_ri_q) + 33'(p_ir_q);
            end
            // Outputs hold their last value between valid samples.
            if (v3_q) begin
                tag4_q <= tag3_q;
                y_q    <= y_d;
            end
        end
    end

    assign valid_o = v4_q;
    assign tag_o   = tag4_q;
    assign y_o     = y_q;

endmodule

// File: rtl/fade_apply.sv
// Collects per-channel fade coefficients into a ping-pong store, swaps banks
// on a complete set and applies the active coefficient to a tagged sample stream.
module fade_apply
    import fader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fade_dv,
    input  logic [W_CHAN-1:0] fade_chan,
    input  logic [15:0]       fade_real,
    input  logic [15:0]       fade_imag,
    input  logic              s_valid,
    input  logic [W_CHAN-1:0] s_chan,
    input  logic [15:0]       s_real,
    input  logic [15:0]       s_imag,
    output logic              m_valid,
    output logic [W_CHAN-1:0] m_chan,
    output logic [15:0]       m_real,
    output logic [15:0]       m_imag,
    output logic              fade_ready,
    output logic              bank_swap,
    output logic              frame_err
);

    cplx16_t             mem_q [2*N_CHAN];
    cplx16_t             coef_q, smp_q, mult_a, mult_b, y;
    logic [N_CHAN-1:0]   mask_q, mask_d, mask_all;
    logic                rd_bank_q, rd_bank_d;
    logic                ready_q, ready_d;
    logic                swap_q, swap_d;
    logic                err_q, err_d;
    logic                v1_q, rdy1_q;
    logic [W_CHAN-1:0]   chan1_q;

    // Write bank is always the inactive one, so reads never collide with writes.
    always_ff @(posedge clk) begin
        if (fade_dv) begin
            mem_q[{~rd_bank_q, fade_chan}] <= '{re: fade_real, im: fade_imag};
        end
        if (s_valid) begin
            coef_q <= mem_q[{rd_bank_q, s_chan}];
        end
    end

    always_comb begin
        mask_all  = mask_q | (N_CHAN'(1) << fade_chan);
        mask_d    = mask_q;
        rd_bank_d = rd_bank_q;
        ready_d   = ready_q;
        swap_d    = 1'b0;
        err_d     = 1'b0;
        if (fade_dv) begin
            if (fade_chan == '0) begin
                mask_d = '0;
                if (&mask_all) begin
                    rd_bank_d = ~rd_bank_q;
                    ready_d   = 1'b1;
                    swap_d    = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                mask_d = mask_all;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q    <= '0;
            rd_bank_q <= 1'b0;
            ready_q   <= 1'b0;
            swap_q    <= 1'b0;
            err_q     <= 1'b0;
            v1_q      <= 1'b0;
            rdy1_q    <= 1'b0;
            chan1_q   <= '0;
            smp_q     <= '0;
        end else begin
            mask_q    <= mask_d;
            rd_bank_q <= rd_bank_d;
            ready_q   <= ready_d;
            swap_q    <= swap_d;
            err_q     <= err_d;
            v1_q      <= s_valid;
            if (s_valid) begin
                rdy1_q  <= ready_q;
                chan1_q <= s_chan;
                smp_q   <= '{re: s_real, im: s_imag};
            end
        end
    end

    // Before the first swap the active bank is unwritten; zero both operands.
    assign mult_a = rdy1_q ? smp_q  : '0;
    assign mult_b = rdy1_q ? coef_q : '0;

    cmult_q13 #(
        .FRAC (FADE_FRAC),
        .TagW (W_CHAN)
    ) u_cmult (
        .clk     (clk),
        .reset   (reset),
        .valid_i (v1_q),
        .tag_i   (chan1_q),
        .a_i     (mult_a),
        .b_i     (mult_b),
        .valid_o (m_valid),
        .tag_o   (m_chan),
        .y_o     (y)
    );

    assign m_real     = y.re;
    assign m_imag     = y.im;
    assign fade_ready = ready_q;
    assign bank_swap  = swap_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_fade_apply.sv
// Directed bench for fade_apply: a reference model predicts every output sample
// into a queue; a negedge monitor pops and compares as samples emerge.
module tb_fade_apply;
    import fader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fade_dv = 1'b0;
    logic [4:0]  fade_chan = '0;
    logic [15:0] fade_real = '0, fade_imag = '0;
    logic        s_valid = 1'b0;
    logic [4:0]  s_chan = '0;
    logic [15:0] s_real = '0, s_imag = '0;
    logic        m_valid;
    logic [4:0]  m_chan;
    logic [15:0] m_real, m_imag;
    logic        fade_ready, bank_swap, frame_err;

    fade_apply dut (
        .clk        (clk),
        .reset      (reset),
        .fade_dv    (fade_dv),
        .fade_chan  (fade_chan),
        .fade_real  (fade_real),
        .fade_imag  (fade_imag),
        .s_valid    (s_valid),
        .s_chan     (s_chan),
        .s_real     (s_real),
        .s_imag     (s_imag),
        .m_valid    (m_valid),
        .m_chan     (m_chan),
        .m_real     (m_real),
        .m_imag     (m_imag),
        .fade_ready (fade_ready),
        .bank_swap  (bank_swap),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [4:0]      ch;
        logic [15:0]     re;
        logic [15:0]     im;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic signed [15:0] act_re[32], act_im[32], pend_re[32], pend_im[32];
    logic signed [15:0] tbl_re[32], tbl_im[32];
    logic [31:0] mask_m = '0;
    bit          ready_m = 1'b0;
    logic [4:0]  last_ch = '0;
    logic [15:0] last_re = '0, last_im = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fx(input longint acc);
        longint r;
        r = (acc + 64'sd4096) >>> 13;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (m_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", {27'd0, m_chan, m_real, m_imag}, 64'hdead);
                end else begin
                    e = sbq.pop_front();
                    chk("sample", {cyc[26:0], m_chan, m_real, m_imag},
                        {e.due[26:0], e.ch, e.re, e.im});
                end
                last_ch = m_chan;
                last_re = m_real;
                last_im = m_imag;
            end else begin
                chk("hold", {27'd0, m_chan, m_real, m_imag}, {27'd0, last_ch, last_re, last_im});
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    chk("missing_out", 64'd0, {e.due[26:0], e.ch, e.re, e.im});
                end
            end
        end
    end

    // One clock: drive a coefficient and/or a sample, predict, then check pulses.
    task automatic step(input bit dv, input int fch, input int fre, input int fim,
                        input bit sv, input int sch, input int sre, input int sim);
        exp_t   e;
        bit     exp_swap, exp_err;
        longint ar, ai;
        fade_dv   = dv;
        fade_chan = fch[4:0];
        fade_real = fre[15:0];
        fade_imag = fim[15:0];
        s_valid   = sv;
        s_chan    = sch[4:0];
        s_real    = sre[15:0];
        s_imag    = sim[15:0];
        if (sv) begin
            e.due = cyc + FADE_APPLY_LAT;
            e.ch  = sch[4:0];
            e.re  = '0;
            e.im  = '0;
            if (ready_m) begin
                ar = longint'(sre) * longint'(act_re[sch]) - longint'(sim) * longint'(act_im[sch]);
                ai = longint'(sre) * longint'(act_im[sch]) + longint'(sim) * longint'(act_re[sch]);
                e.re = fx(ar);
                e.im = fx(ai);
            end
            sbq.push_back(e);
        end
        exp_swap = 1'b0;
        exp_err  = 1'b0;
        if (dv) begin
            pend_re[fch] = fre[15:0];
            pend_im[fch] = fim[15:0];
            mask_m = mask_m | (32'd1 << fch);
            if (fch == 0) begin
                if (&mask_m) begin
                    act_re   = pend_re;
                    act_im   = pend_im;
                    ready_m  = 1'b1;
                    exp_swap = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
                mask_m = '0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        fade_dv = 1'b0;
        s_valid = 1'b0;
        chk("pulses", {61'd0, bank_swap, frame_err, fade_ready},
            {61'd0, exp_swap, exp_err, ready_m});
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_from(input int hi);
        for (int c = hi; c >= 0; c--) step(1, c, tbl_re[c], tbl_im[c], 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_now", {61'd0, fade_ready, m_valid, bank_swap}, 64'd0);
        sbq.delete();
        mask_m  = '0;
        ready_m = 1'b0;
        last_ch = '0;
        last_re = '0;
        last_im = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outs", {26'd0, fade_ready, m_valid, m_chan, m_real, m_imag}, 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 32; c++) begin
            tbl_re[c] = 16'sd8192;
            tbl_im[c] = 16'sd0;
        end
        @(negedge clk);
        do_reset();
        chk("reset_pulses", {62'd0, frame_err, bank_swap}, 64'd0);

        // Not ready yet: samples flow with zero data.
        step(0, 0, 0, 0, 1, 4, 123, 45);
        tick(5);

        // Unity set.
        load_from(31);
        chk("ready_after_load", {63'd0, fade_ready}, 64'd1);
        step(0, 0, 0, 0, 1, 5, 1000, -200);
        tick(5);

        // Rotation on ch7.
        tbl_re[7] = 16'sd0;
        tbl_im[7] = 16'sd8192;
        load_from(31);
        step(0, 0, 0, 0, 1, 7, 1000, 200);
        step(0, 0, 0, 0, 1, 6, 1000, 200);
        tick(5);

        // Saturation and rounding.
        tbl_re[0] = 16'sd16376;  tbl_im[0] = 16'sd16376;
        tbl_re[1] = -16'sd16376; tbl_im[1] = 16'sd0;
        tbl_re[2] = 16'sd4096;   tbl_im[2] = 16'sd0;
        load_from(31);
        step(0, 0, 0, 0, 1, 0, 32767, 0);
        step(0, 0, 0, 0, 1, 1, 32767, 0);
        step(0, 0, 0, 0, 1, 2, 3, 0);
        step(0, 0, 0, 0, 1, 2, -3, 0);
        tick(5);

        // Incomplete set: chans 31..5 then 0; old coefficients stay active.
        for (int c = 31; c >= 5; c--) step(1, c, -8192, 100, 0, 0, 0, 0);
        step(1, 0, -8192, 100, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 7, 1000, 200);
        step(0, 0, 0, 0, 1, 0, 32767, 0);
        tick(5);
        for (int c = 0; c < 32; c++) begin
            tbl_re[c] = 16'sd8192;
            tbl_im[c] = 16'sd0;
        end
        tbl_re[3] = -16'sd8192;
        load_from(31);
        step(0, 0, 0, 0, 1, 3, 500, 60);
        tick(5);

        // Swap boundary with back-to-back ch3 samples.
        tbl_re[3] = 16'sd0;
        tbl_im[3] = 16'sd8192;
        load_from(31);
        tbl_re[3] = 16'sd0;
        tbl_im[3] = 16'sd8192;
        for (int c = 31; c >= 4; c--) step(1, c, tbl_re[c], tbl_im[c], 0, 0, 0, 0);
        tbl_re[3] = -16'sd4096;
        tbl_im[3] = 16'sd2048;
        for (int c = 3; c >= 0; c--) step(1, c, tbl_re[c], tbl_im[c], 1, 3, 100 + c, 7);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 3, 200 + i, -9);
        tick(5);

        // Reset mid-load and mid-pipeline.
        for (int c = 31; c >= 20; c--) step(1, c, 8192, 0, 1, c, 1000, 1000);
        do_reset();
        step(0, 0, 0, 0, 1, 9, 777, -777);
        tick(5);
        for (int c = 31; c >= 1; c--) step(1, c, 4096, -4096, 0, 0, 0, 0);
        step(1, 0, 4096, -4096, 1, 9, 777, -777);
        step(0, 0, 0, 0, 1, 9, 777, -777);
        tick(6);

        chk("queue_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
